cpu_mem_responder: RTL and testbench

Memory-side responder for the CPU's single-port bus (ce/we/addr/data). It stores program and data words and answers CPU reads with one cycle of latency. A host load port fills the memory before the CPU runs. `o_cpu_run` gates the CPU's `reset_n` at top level, so the CPU only starts once loading is complete.

---
 rtl/cpu_mem_responder.sv | 135 +++++++++++++
 tb/tb_cpu_mem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU bus: host load port, then registered 1-cycle CPU reads.
// Optional macro MEM_CLEAR_ON_RESET_EN zero-fills the array after reset before loading.
module cpu_mem_responder #(
    parameter int DWIDTH     = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_DEPTH  = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_ce,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0]     i_data,
    output logic [DWIDTH-1:0]     o_data,
    input  logic                  i_ld_valid,
    input  logic [ADDR_WIDTH-1:0] i_ld_addr,
    input  logic [DWIDTH-1:0]     i_ld_data,
    output logic                  o_ld_ready,
    input  logic                  i_ld_done,
    output logic                  o_cpu_run,
    output logic                  o_oob_err
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

`ifdef MEM_CLEAR_ON_RESET_EN
    typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_RUN} state_t;
    localparam state_t RESET_STATE = ST_CLEAR;
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
`else
    typedef enum logic {ST_LOAD, ST_RUN} state_t;
    localparam state_t RESET_STATE = ST_LOAD;
`endif

    state_t state, state_next;

    logic [DWIDTH-1:0] mem [MEM_DEPTH];

    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DWIDTH-1:0] mem_wdata;
    logic              cpu_in_range;
    logic              ld_in_range;

    // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH compares correctly.
    assign cpu_in_range = ({1'b0, i_addr}    < (ADDR_WIDTH+1)'(MEM_DEPTH));
    assign ld_in_range  = ({1'b0, i_ld_addr} < (ADDR_WIDTH+1)'(MEM_DEPTH));

    assign o_ld_ready = (state == ST_LOAD);
    assign o_cpu_run  = (state == ST_RUN);

`ifdef MEM_CLEAR_ON_RESET_EN
    logic [ADDR_WIDTH-1:0] clr_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        case (state)
`ifdef MEM_CLEAR_ON_RESET_EN
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt[IDX_W-1:0];
                if (clr_cnt == CLR_LAST) begin
                    state_next = ST_LOAD;
                end
            end
`endif
            ST_LOAD: begin
                // A word presented together with done is still written.
                if (i_ld_valid && ld_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = i_ld_addr[IDX_W-1:0];
                    mem_wdata = i_ld_data;
                end
                if (i_ld_done) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_ce && i_we && cpu_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = i_addr[IDX_W-1:0];
                    mem_wdata = i_data;
                end
            end
            default: state_next = RESET_STATE;
        endcase
    end

    // Array has no reset so contents survive a CPU reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_data    <= '0;
            o_oob_err <= 1'b0;
        end else begin
            if (state == ST_RUN && i_ce) begin
                if (!cpu_in_range) begin
                    o_oob_err <= 1'b1;
                end
                if (!i_we) begin
                    o_data <= cpu_in_range ? mem[i_addr[IDX_W-1:0]] : '0;
                end
            end
            if (state == ST_LOAD && i_ld_valid && !ld_in_range) begin
                o_oob_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed steps plus random RUN traffic
// checked against a mode/associative-array reference model.
module tb_cpu_mem_responder;

    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int DEPTH = 1024;
`ifdef MEM_CLEAR_ON_RESET_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_ce = 1'b0;
    logic          i_we = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_data = '0;
    logic [DW-1:0] o_data;
    logic          i_ld_valid = 1'b0;
    logic [AW-1:0] i_ld_addr = '0;
    logic [DW-1:0] i_ld_data = '0;
    logic          o_ld_ready;
    logic          i_ld_done = 1'b0;
    logic          o_cpu_run;
    logic          o_oob_err;

    always #5 clk = ~clk;

    cpu_mem_responder #(
        .DWIDTH    (DW),
        .ADDR_WIDTH(AW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_ce      (i_ce),
        .i_we      (i_we),
        .i_addr    (i_addr),
        .i_data    (i_data),
        .o_data    (o_data),
        .i_ld_valid(i_ld_valid),
        .i_ld_addr (i_ld_addr),
        .i_ld_data (i_ld_data),
        .o_ld_ready(o_ld_ready),
        .i_ld_done (i_ld_done),
        .o_cpu_run (o_cpu_run),
        .o_oob_err (o_oob_err)
    );

    // Reference model: mode 0 = clearing, 1 = loading, 2 = running.
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] mm [int];
    logic [DW-1:0] exp_data;
    bit            data_known;
    bit            exp_oob;
    int            mode;
    int            clear_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".cpu_run"},  32'(o_cpu_run),  32'(mode == 2));
        chk({tag, ".ld_ready"}, 32'(o_ld_ready), 32'(mode == 1));
        chk({tag, ".oob_err"},  32'(o_oob_err),  32'(exp_oob));
        if (data_known) chk({tag, ".o_data"}, 32'(o_data), 32'(exp_data));
    endtask

    task automatic cyc(input string tag, input bit ce, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input bit ldv, input logic [AW-1:0] la,
                       input logic [DW-1:0] ld, input bit done);
        i_ce = ce; i_we = we; i_addr = addr; i_data = data;
        i_ld_valid = ldv; i_ld_addr = la; i_ld_data = ld; i_ld_done = done;
        case (mode)
            0: begin
                clear_left--;
                if (clear_left == 0) mode = 1;
            end
            1: begin
                if (ldv) begin
                    if (int'(la) < DEPTH) mm[int'(la)] = ld;
                    else exp_oob = 1'b1;
                end
                if (done) mode = 2;
            end
            default: begin
                if (ce) begin
                    if (int'(addr) >= DEPTH) begin
                        exp_oob = 1'b1;
                        if (!we) begin
                            exp_data = '0;
                            data_known = 1'b1;
                        end
                    end else if (we) begin
                        mm[int'(addr)] = data;
                    end else if (mm.exists(int'(addr))) begin
                        exp_data = mm[int'(addr)];
                        data_known = 1'b1;
                    end else begin
                        data_known = 1'b0;
                    end
                end
            end
        endcase
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    task automatic do_reset(input string tag);
        i_ce = 1'b0; i_we = 1'b0; i_ld_valid = 1'b0; i_ld_done = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        mode = CLEAR_EN ? 0 : 1;
        clear_left = DEPTH;
        exp_data = '0;
        data_known = 1'b1;
        exp_oob = 1'b0;
        if (CLEAR_EN) begin
            for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        end
        #1;
        check_outs({tag, ".async"});
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_outs({tag, ".release"});
    endtask

    // Host and CPU activity during CLEAR must be ignored.
    task automatic wait_load();
        for (int i = 0; i < DEPTH + 4 && mode == 0; i++) begin
            cyc("clear", 1'b1, 1'b1, 12'h003, 16'h1111, 1'b1, 12'h003, 16'hFFFF, 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset("rst1");
        wait_load();

        cyc("load_cpu_rd",  1, 0, 12'h000, 16'h0000, 0, 12'h000, 16'h0000, 0);
        cyc("load_w0",      0, 0, 12'h000, 16'h0000, 1, 12'h000, 16'h1234, 0);
        cyc("load_w5",      0, 0, 12'h000, 16'h0000, 1, 12'h005, 16'hBEEF, 0);
        cyc("load_w3",      1, 1, 12'h003, 16'h7777, 1, 12'h003, 16'hFFFF, 0);
        cyc("load_done",    0, 0, 12'h000, 16'h0000, 0, 12'h000, 16'h0000, 1);
        cyc("run_rd5",      1, 0, 12'h005, 16'h0000, 0, 12'h000, 16'h0000, 0);
        cyc("run_host_w",   0, 0, 12'h000, 16'h0000, 1, 12'h005, 16'h5555, 1);
        cyc("run_rd5b",     1, 0, 12'h005, 16'h0000, 0, 12'h000, 16'h0000, 0);
        cyc("run_wr10",     1, 1, 12'h010, 16'hA5A5, 0, 12'h000, 16'h0000, 0);
        cyc("run_rd10",     1, 0, 12'h010, 16'h0000, 0, 12'h000, 16'h0000, 0);
        cyc("run_idle",     0, 0, 12'h005, 16'h0000, 0, 12'h000, 16'h0000, 0);
        cyc("oob_rd400",    1, 0, 12'h400, 16'h0000, 0, 12'h000, 16'h0000, 0);
        cyc("oob_wr7ff",    1, 1, 12'h7FF, 16'hDEAD, 0, 12'h000, 16'h0000, 0);
        cyc("after_oob_rd", 1, 0, 12'h000, 16'h0000, 0, 12'h000, 16'h0000, 0);
        cyc("rd3",          1, 0, 12'h003, 16'h0000, 0, 12'h000, 16'h0000, 0);

        for (int i = 0; i < 300; i++) begin
            bit            ce;
            bit            we;
            logic [AW-1:0] a;
            ce = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 15) == 0) a = 12'(DEPTH + $urandom_range(0, 3071));
            else a = 12'($urandom_range(64, 127));
            cyc("rand", ce, we, a, 16'($urandom), ($urandom_range(0, 1) != 0),
                12'($urandom_range(0, 127)), 16'($urandom), ($urandom_range(0, 1) != 0));
        end

        do_reset("rst2");
        wait_load();
        cyc("load_oob",     0, 0, 12'h000, 16'h0000, 1, 12'h800, 16'h9999, 0);
        cyc("valid_done",   0, 0, 12'h000, 16'h0000, 1, 12'h020, 16'h0042, 1);
        cyc("rd20",         1, 0, 12'h020, 16'h0000, 0, 12'h000, 16'h0000, 0);
        cyc("rd3_again",    1, 0, 12'h003, 16'h0000, 0, 12'h000, 16'h0000, 0);
        cyc("rd5_again",    1, 0, 12'h005, 16'h0000, 0, 12'h000, 16'h0000, 0);
        cyc("rd10_again",   1, 0, 12'h010, 16'h0000, 0, 12'h000, 16'h0000, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
